out_serialiser: RTL

OUT_SERIALISER -- requirements
Module: out_serialiser

---
 rtl/out_serialiser.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/out_serialiser.sv
// Double-buffered TDM output serialiser: the sequencer fills one bank while the other shifts out MSB first.
// Optional build macro OUT_MUTE_ON_UNDERRUN_EN: a frame that starts without a fresh bank is sent as silence.
module out_serialiser #(
    parameter int unsigned DIV      = 4,
    parameter int unsigned CHANNELS = 16
) (
    input  logic                        ck,
    input  logic                        rst,
    input  logic                        we,
    input  logic [$clog2(CHANNELS)-1:0] waddr,
    input  logic [15:0]                 wdata,
    input  logic                        done,
    output logic                        sck,
    output logic                        ws,
    output logic                        sd,
    output logic                        underrun
);
    localparam int unsigned AW = $clog2(CHANNELS);
    localparam int unsigned BW = AW + 4;
    localparam int unsigned DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(16 * CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, SYNC, SHIFT} state_t;

    state_t        state;
    logic          wsel;
    logic          swap_pending;
    logic          done_q;
    logic          mute;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [15:0]   bank [2][CHANNELS];

    logic          done_rise;
    logic          shift_evt;
    logic          rd_sel;
    logic          mute_nxt;
    logic [BW-1:0] bit_nxt;
    logic [15:0]   word_nxt;
    logic          sd_nxt;

    assign done_rise = done & ~done_q;
    assign shift_evt = sck & (div_cnt == DIV_LAST);

    // Bit to present at the next shift event; on the SYNC exit it comes from the bank about to become the read bank.
    always_comb begin
        rd_sel   = ~wsel;
        mute_nxt = mute;
        bit_nxt  = bit_cnt + BW'(1);
        if (state == SYNC) begin
            bit_nxt = '0;
            if (swap_pending) begin
                rd_sel   = wsel;
                mute_nxt = 1'b0;
            end else begin
`ifdef OUT_MUTE_ON_UNDERRUN_EN
                mute_nxt = 1'b1;
`else
                mute_nxt = 1'b0;
`endif
            end
        end
        word_nxt = bank[rd_sel][bit_nxt[BW-1:4]];
        sd_nxt   = word_nxt[4'd15 - bit_nxt[3:0]] & ~mute_nxt;
    end

    // Sample storage is never reset; writes always land in the current fill bank.
    always_ff @(posedge ck) begin
        if (!rst && we) begin
            bank[wsel][waddr] <= wdata;
        end
    end

    always_ff @(posedge ck) begin
        done_q <= done;
        if (rst) begin
            state        <= IDLE;
            wsel         <= 1'b0;
            swap_pending <= 1'b0;
            mute         <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            sck          <= 1'b0;
            ws           <= 1'b0;
            sd           <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (done_rise) begin
                swap_pending <= 1'b1;
            end
            if (state != IDLE) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    sck     <= ~sck;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (swap_pending) begin
                        state <= SYNC;
                        ws    <= 1'b1;
                    end
                end
                SYNC: begin
                    if (shift_evt) begin
                        state   <= SHIFT;
                        ws      <= 1'b0;
                        sd      <= sd_nxt;
                        bit_cnt <= '0;
                        mute    <= mute_nxt;
                        // A done edge landing on the swap cycle itself arms the following frame.
                        if (swap_pending) begin
                            wsel         <= ~wsel;
                            swap_pending <= done_rise;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (shift_evt) begin
                        if (bit_cnt == BIT_LAST) begin
                            state   <= SYNC;
                            ws      <= 1'b1;
                            sd      <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            sd      <= sd_nxt;
                            bit_cnt <= bit_nxt;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
